// File: rtl/sap_program_loader.sv
// Loads a framed byte stream (count, data, checksum) into the 16x8 program RAM,
// zero-fills the unused tail, then releases the CPU via cpu_run.
module sap_program_loader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              load_start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [DATA_W-1:0] cpu_data,
  output logic              cpu_run,
  output logic              busy,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH-1);

  typedef enum logic [2:0] {IDLE, HEADER, DATA, CHECK, FILL, DONE, ERR} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W:0]   cnt;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              we;
  logic [DATA_W-1:0] wdata;
  logic              xfer, hdr_ok, last_byte;

  assign in_ready  = (state == HEADER) || (state == DATA) || (state == CHECK);
  assign busy      = in_ready || (state == FILL);
  assign err       = (state == ERR);
  assign xfer      = in_valid & in_ready;
  assign hdr_ok    = (in_data != '0) && (32'(in_data) <= 32'(DEPTH));
  assign last_byte = ((words_loaded + (ADDR_W+1)'(1)) == cnt);
  assign cpu_data  = mem[cpu_addr];

  always_ff @(posedge clk or negedge clr)
    if (!clr) state <= IDLE;
    else      state <= state_nxt;

  always_comb begin
    state_nxt = state;
    we        = 1'b0;
    wdata     = in_data;
    case (state)
      IDLE:   if (load_start) state_nxt = HEADER;
      HEADER: if (xfer) state_nxt = hdr_ok ? DATA : ERR;
      DATA: if (xfer) begin
        we = 1'b1;
        if (last_byte) state_nxt = CHECK;
      end
      CHECK: if (xfer)
        state_nxt = (in_data != sum) ? ERR : (cnt == DEPTH_C) ? DONE : FILL;
      FILL: begin
        we    = 1'b1;
        wdata = '0;
        if (addr == LAST_A) state_nxt = DONE;
      end
      DONE, ERR: if (load_start) state_nxt = HEADER;
      default:   state_nxt = IDLE;
    endcase
    // A restart wins over any byte or fill write landing in the same cycle.
    if (load_start) begin
      state_nxt = HEADER;
      we        = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge clr)
    if (!clr) begin
      cnt          <= '0;
      addr         <= '0;
      sum          <= '0;
      words_loaded <= '0;
      cpu_run      <= 1'b0;
    end else begin
      cpu_run <= (state == DONE);
      if (load_start) begin
        words_loaded <= '0;
        sum          <= '0;
      end else begin
        case (state)
          HEADER: if (xfer) begin
            cnt  <= in_data[ADDR_W:0];
            addr <= '0;
            sum  <= '0;
          end
          DATA: if (xfer) begin
            addr         <= addr + ADDR_W'(1);
            sum          <= sum + in_data;
            words_loaded <= words_loaded + (ADDR_W+1)'(1);
          end
          FILL:    addr <= addr + ADDR_W'(1);
          default: ;
        endcase
      end
    end

  // RAM is deliberately left out of reset so an image survives clr.
  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;

endmodule
